// File: rtl/bus_mux_pkg.sv
// Shared types and constants for the bus mux arbiter: FSM state encoding,
// default channel count and width, and a constant-foldable ceil(log2) helper.
package bus_mux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after i_ptr,
// wrapping modulo N, returned both one-hot and as a binary index.
module rr_arbiter
  import bus_mux_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx
);

  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[(int'(i_ptr) + k) % N]) begin
        w_found                            = 1'b1;
        o_grant[(int'(i_ptr) + k) % N] = 1'b1;
        o_idx                              = PW'((int'(i_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/bus_mux_arbiter.sv
// N-channel round-robin bus multiplexer with a one-word output register;
// captures a new word on the same edge the held word is accepted downstream.
module bus_mux_arbiter
  import bus_mux_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic [N*W-1:0]      din,
  output logic [N-1:0]        ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_data,
  output logic [clog2(N)-1:0] out_src
);

  localparam int PW = clog2(N);

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [W-1:0]  r_data;
  logic [PW-1:0] r_src;

  logic [N-1:0]  w_grant;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_nextPtr;
  logic [W-1:0]  w_muxData;
  logic          w_capture;

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_muxData = '0;
    for (int i = 0; i < N; i++) begin
      w_muxData = w_muxData | (din[i*W +: W] & {W{w_grant[i]}});
    end
  end

  // ack is combinational so a channel sees it in the cycle its word is taken;
  // rst_n gates it so reset silences ack immediately.
  assign w_capture = rst_n && (|req) && ((r_state == EMPTY) || out_ready);
  assign ack       = w_capture ? w_grant : '0;
  assign w_nextPtr = (w_idx == PW'(N - 1)) ? '0 : w_idx + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_data  <= '0;
      r_src   <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_capture) begin
            r_data  <= w_muxData;
            r_src   <= w_idx;
            r_ptr   <= w_nextPtr;
            r_state <= FULL;
          end
        end
        FULL: begin
          if (w_capture) begin
            r_data  <= w_muxData;
            r_src   <= w_idx;
            r_ptr   <= w_nextPtr;
          end else if (out_ready) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Scoreboard bench for bus_mux_arbiter: directed scenarios then random traffic,
// checked against a queue-based round-robin reference model.
module tb_bus_mux_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int PW = 2;

  typedef struct {
    logic [W-1:0] data;
    int           src;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*W-1:0] din;
  logic [N-1:0]  ack;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [PW-1:0] out_src;

  int testCount = 0;
  int failCount = 0;

  exp_t         sbQ[$];
  bit           pend[N];
  logic [W-1:0] pdata[N];
  bit           mFull;
  int           mPtr;

  bus_mux_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of traffic: drive the channels, predict the grant from the
  // round-robin rule, and queue the word that will be captured.
  task automatic applyStimulus(input logic rdy, input logic rel);
    logic [N-1:0] expAck;
    int win;
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      req[i]         = pend[i];
      din[i*W +: W]  = pdata[i];
    end
    out_ready = rdy;
    if (rel) rst_n = 1'b1;
    #1;
    checkOutput("out_valid", out_valid, mFull);
    win = -1;
    if (req != '0 && (!mFull || rdy)) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && pend[(mPtr + k) % N]) win = (mPtr + k) % N;
      end
    end
    expAck = '0;
    if (win >= 0) expAck[win] = 1'b1;
    checkOutput("ack", ack, expAck);
    if (win >= 0) begin
      e.data = pdata[win];
      e.src  = win;
      sbQ.push_back(e);
      mPtr      = (win + 1) % N;
      mFull     = 1'b1;
      pend[win] = 1'b0;
    end else if (mFull && rdy) begin
      mFull = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL sb_underflow: got word %0h src %0d expected none", out_data, out_src);
      end else begin
        e = sbQ.pop_front();
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_src", out_src, e.src);
      end
    end
  end

  task automatic clearPend();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    din       = '0;
    out_ready = 1'b0;
    mFull     = 1'b0;
    mPtr      = 0;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b1;
      pdata[i] = W'($urandom);
      din[i*W +: W] = pdata[i];
    end
    req = '1;
    #2;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_data", out_data, 0);
    checkOutput("rst_src", out_src, 0);

    // Release with every channel requesting; channel 0 must lead the rotation.
    applyStimulus(1'b1, 1'b1);
    checkOutput("rr_ack0", ack, 4'b0001);
    for (int i = 1; i < 5; i++) begin
      for (int c = 0; c < N; c++) begin
        if (!pend[c]) begin
          pend[c]  = 1'b1;
          pdata[c] = W'($urandom);
        end
      end
      applyStimulus(1'b1, 1'b0);
      if (i == 1) checkOutput("first_src", out_src, 0);
      checkOutput("rr_ack", ack, 4'b0001 << (i % 4));
    end
    clearPend();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);

    // Back-pressure holds A5 while ch2/ch3 wait.
    pend[1] = 1'b1; pdata[1] = 8'hA5;
    applyStimulus(1'b0, 1'b0);
    pend[2] = 1'b1; pdata[2] = 8'h5A;
    pend[3] = 1'b1; pdata[3] = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("bp_data", out_data, 8'hA5);
      checkOutput("bp_ack", ack, 0);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("bp_resume_ack", ack, 4'b0100);
    clearPend();
    applyStimulus(1'b1, 1'b0);
    checkOutput("bp_next_data", out_data, 8'h5A);
    applyStimulus(1'b1, 1'b0);

    // Wrap from ptr=3 past idle ch3/ch0 to ch1, then ch2.
    pend[2] = 1'b1; pdata[2] = 8'h21;
    applyStimulus(1'b1, 1'b0);
    pend[1] = 1'b1; pdata[1] = 8'h11;
    pend[2] = 1'b1; pdata[2] = 8'h22;
    applyStimulus(1'b1, 1'b0);
    checkOutput("wrap_ack1", ack, 4'b0010);
    applyStimulus(1'b1, 1'b0);
    checkOutput("wrap_ack2", ack, 4'b0100);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);

    // Single word drains back to EMPTY.
    pend[2] = 1'b1; pdata[2] = 8'h3C;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("drain_data", out_data, 8'h3C);
    applyStimulus(1'b1, 1'b0);
    checkOutput("drain_valid", out_valid, 0);

    // Async reset mid-cycle while FULL with another request pending.
    pend[0] = 1'b1; pdata[0] = 8'h77;
    applyStimulus(1'b0, 1'b0);
    pend[1] = 1'b1; pdata[1] = 8'h99;
    applyStimulus(1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", out_valid, 0);
    checkOutput("async_ack", ack, 0);
    mFull = 1'b0;
    mPtr  = 0;
    sbQ.delete();
    applyStimulus(1'b1, 1'b1);

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!pend[c] && ($urandom % 3 == 0)) begin
          pend[c]  = 1'b1;
          pdata[c] = W'($urandom);
        end else if (pend[c] && ($urandom % 16 == 0)) begin
          pend[c] = 1'b0;
        end
      end
      applyStimulus(($urandom % 4) != 0, 1'b0);
    end

    clearPend();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("sb_drained", sbQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
